// File: rtl/fp32_pkg.sv
// Shared types and constants for the fp32 -> int32 converter.
//   fp32_t       : packed {sign, exp, frac} view of an fp32 word
//   cvt_state_t  : converter FSM states
//   sat_val      : saturation value for a given sign
//   apply_sign   : two's-complement negate a magnitude when sign is set
package fp32_pkg;

   localparam int               EXP_W     = 8;
   localparam int               FRAC_W    = 23;
   localparam logic [EXP_W-1:0] FP32_BIAS = 8'd127;
   localparam logic [31:0]      INT_MAX   = 32'h7FFF_FFFF;
   localparam logic [31:0]      INT_MIN   = 32'h8000_0000;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } fp32_t;

   typedef enum logic [1:0] {IDLE, SHIFT, OUT} cvt_state_t;

   function automatic logic [31:0] sat_val(input logic s);
      return s ? INT_MIN : INT_MAX;
   endfunction

   function automatic logic [31:0] apply_sign(input logic s, input logic [31:0] m);
      return s ? (~m + 32'd1) : m;
   endfunction

endpackage

// File: rtl/fp32_to_int32_seq_if.sv
// Operand/result handshake bundle for fp32_to_int32_seq.
//   din/in_valid/in_ready        : fp32 operand channel
//   dout/out_valid/out_ready     : int32 result channel
//   ovf/nv                       : result flags, qualified by out_valid
// master = producer+consumer side, slave = converter.
interface fp32_to_int32_seq_if;
   logic [31:0] din;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] dout;
   logic        out_valid;
   logic        out_ready;
   logic        ovf;
   logic        nv;

   modport master (output din, in_valid, out_ready,
                   input  in_ready, dout, out_valid, ovf, nv);
   modport slave  (input  din, in_valid, out_ready,
                   output in_ready, dout, out_valid, ovf, nv);
endinterface

// File: rtl/fp32_classify.sv
// Combinational decode of an fp32 word.
//   din      : fp32 operand
//   sign     : din sign bit
//   frac     : din fraction field
//   is_nan   : exp all ones, frac nonzero
//   is_inf   : exp all ones, frac zero
//   is_small : |x| < 1.0 (includes zero and denormals)
//   u        : unbiased exponent exp-127 (meaningful only when !is_small)
module fp32_classify
   import fp32_pkg::*;
(
   input  logic [31:0]       din,
   output logic              sign,
   output logic [FRAC_W-1:0] frac,
   output logic              is_nan,
   output logic              is_inf,
   output logic              is_small,
   output logic [EXP_W-1:0]  u
);
   fp32_t f;
   assign f        = din;
   assign sign     = f.sign;
   assign frac     = f.frac;
   assign is_nan   = (f.exp == '1) && (f.frac != '0);
   assign is_inf   = (f.exp == '1) && (f.frac == '0);
   assign is_small = (f.exp < FP32_BIAS);
   assign u        = f.exp - FP32_BIAS;
endmodule

// File: rtl/fp32_to_int32_seq.sv
// Iterative fp32 -> signed int32 converter, round toward zero, saturating.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of fp32_to_int32_seq_if (operand in, result out)
//   STEP     : bits shifted per SHIFT cycle (1, 2, 4 or 8)
// Special operands resolve on the accept edge; normal operands shift the
// 24-bit significand toward binary point position 0, STEP bits per cycle.
module fp32_to_int32_seq
   import fp32_pkg::*;
#(
   parameter int STEP = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   fp32_to_int32_seq_if.slave   bus
);
   localparam logic [4:0]  STEP_W   = 5'(STEP);
   // -2^31 is exactly representable and is the only |x| >= 2^31 that fits.
   localparam logic [31:0] FP_M2P31 = 32'hCF00_0000;

   cvt_state_t        state_q;
   logic [31:0]       mag_q;
   logic [4:0]        cnt_q;
   logic              left_q;
   logic              sign_q;

   logic              sign, is_nan, is_inf, is_small;
   logic [FRAC_W-1:0] frac;
   logic [EXP_W-1:0]  u;

   fp32_classify u_cls (
      .din      (bus.din),
      .sign     (sign),
      .frac     (frac),
      .is_nan   (is_nan),
      .is_inf   (is_inf),
      .is_small (is_small),
      .u        (u)
   );

   logic [4:0]  u_lo, cnt_init, k;
   logic [31:0] mag_init, mag_sh;

   // Low bits suffice for the shift count: only u in 0..30 reaches SHIFT.
   assign u_lo     = u[4:0];
   assign cnt_init = (u_lo > 5'd23) ? (u_lo - 5'd23) : (5'd23 - u_lo);
   assign mag_init = {8'd0, 1'b1, frac};
   assign k        = (cnt_q < STEP_W) ? cnt_q : STEP_W;
   assign mag_sh   = left_q ? (mag_q << k) : (mag_q >> k);

   assign bus.in_ready = (state_q == IDLE) && !rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         mag_q         <= '0;
         cnt_q         <= '0;
         left_q        <= 1'b0;
         sign_q        <= 1'b0;
         bus.dout      <= '0;
         bus.out_valid <= 1'b0;
         bus.ovf       <= 1'b0;
         bus.nv        <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (bus.in_valid) begin
               sign_q <= sign;
               if (is_nan) begin
                  bus.dout      <= '0;
                  bus.nv        <= 1'b1;
                  bus.out_valid <= 1'b1;
                  state_q       <= OUT;
               end else if (is_inf) begin
                  bus.dout      <= sat_val(sign);
                  bus.ovf       <= 1'b1;
                  bus.out_valid <= 1'b1;
                  state_q       <= OUT;
               end else if (is_small) begin
                  bus.dout      <= '0;
                  bus.out_valid <= 1'b1;
                  state_q       <= OUT;
               end else if (bus.din == FP_M2P31) begin
                  bus.dout      <= INT_MIN;
                  bus.out_valid <= 1'b1;
                  state_q       <= OUT;
               end else if (u >= 8'd31) begin
                  bus.dout      <= sat_val(sign);
                  bus.ovf       <= 1'b1;
                  bus.out_valid <= 1'b1;
                  state_q       <= OUT;
               end else begin
                  mag_q  <= mag_init;
                  cnt_q  <= cnt_init;
                  left_q <= (u_lo > 5'd23);
                  if (cnt_init == 5'd0) begin
                     bus.dout      <= apply_sign(sign, mag_init);
                     bus.out_valid <= 1'b1;
                     state_q       <= OUT;
                  end else begin
                     state_q <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               mag_q <= mag_sh;
               cnt_q <= cnt_q - k;
               // Final step: the shifted value goes straight to dout.
               if (cnt_q == k) begin
                  bus.dout      <= apply_sign(sign_q, mag_sh);
                  bus.out_valid <= 1'b1;
                  state_q       <= OUT;
               end
            end
            OUT: if (bus.out_ready) begin
               bus.out_valid <= 1'b0;
               bus.ovf       <= 1'b0;
               bus.nv        <= 1'b0;
               state_q       <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule
